data_mem_mmio: RTL and testbench

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

---
 rtl/data_mem_mmio.sv | 156 +++++++++++++++
 tb/tb_data_mem_mmio.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// Data memory with byte/half/word access plus a small MMIO window (LED, BCD, SYSTICK, optional timer).
// Define DATA_MEM_TIMER_EN to build the TH/TL/TCON timer and its irq; otherwise those offsets read 0.
module data_mem_mmio #(
    parameter int unsigned RAM_DEPTH = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h4000_0000,
    parameter int unsigned LED_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Address,
    input  logic [31:0]      Write_data,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [1:0]       MemSize,
    input  logic             MemSigned,
    output logic [31:0]      Read_data,
    output logic [LED_W-1:0] led,
    output logic [11:0]      BCD,
    output logic             irq,
    output logic             mem_err
);

    localparam int unsigned AW = $clog2(RAM_DEPTH);

    logic          ram_hit_c, mmio_hit_c, misalign_c, access_c, err_c;
    logic          ram_we_c, mmio_we_c;
    logic [AW-1:0] ram_idx_c;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c, ram_word_c, lane_c, mmio_word_c;
    logic [31:0]   ram_rd [RAM_DEPTH];
    logic [31:0]   systick_q, th_q, tl_q;
    logic [2:0]    tcon_q;

    // Address decode and error classification
    always_comb begin
        ram_hit_c  = (Address[31:AW+2] == '0);
        mmio_hit_c = (Address[31:6] == MMIO_BASE[31:6]);
        misalign_c = 1'b0;
        case (MemSize)
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = Address[0];
            2'b10:   misalign_c = |Address[1:0];
            default: misalign_c = 1'b1;
        endcase
        access_c  = MemRead | MemWrite;
        err_c     = access_c & (misalign_c | ~(ram_hit_c | mmio_hit_c));
        ram_we_c  = MemWrite & ~err_c & ram_hit_c;
        mmio_we_c = MemWrite & ~err_c & mmio_hit_c;
        ram_idx_c = Address[AW+1:2];
    end

    // Store lane enables and lane-replicated write data
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = Write_data;
        case (MemSize)
            2'b00: begin
                be_c    = 4'b0001 << Address[1:0];
                wdata_c = {4{Write_data[7:0]}};
            end
            2'b01: begin
                be_c    = Address[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{Write_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = Write_data;
            end
        endcase
    end

    for (genvar g = 0; g < int'(RAM_DEPTH); g++) begin : g_ram
        logic [31:0] word_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                word_q <= '0;
            end else if (ram_we_c && ram_idx_c == AW'(g)) begin
                if (be_c[0]) word_q[7:0]   <= wdata_c[7:0];
                if (be_c[1]) word_q[15:8]  <= wdata_c[15:8];
                if (be_c[2]) word_q[23:16] <= wdata_c[23:16];
                if (be_c[3]) word_q[31:24] <= wdata_c[31:24];
            end
        end
        assign ram_rd[g] = word_q;
    end

    // Load path: lane extract for RAM, whole register for MMIO
    always_comb begin
        ram_word_c = ram_rd[ram_idx_c];
        lane_c     = ram_word_c >> {Address[1:0], 3'b000};
        case (MemSize)
            2'b00:   lane_c = MemSigned ? {{24{lane_c[7]}}, lane_c[7:0]}
                                        : {24'b0, lane_c[7:0]};
            2'b01:   lane_c = MemSigned ? {{16{lane_c[15]}}, lane_c[15:0]}
                                        : {16'b0, lane_c[15:0]};
            default: lane_c = ram_word_c;
        endcase
        case (Address[5:2])
            4'h0:    mmio_word_c = th_q;
            4'h1:    mmio_word_c = tl_q;
            4'h2:    mmio_word_c = {29'b0, tcon_q};
            4'h3:    mmio_word_c = 32'(led);
            4'h4:    mmio_word_c = {20'b0, BCD};
            4'h5:    mmio_word_c = systick_q;
            default: mmio_word_c = '0;
        endcase
        Read_data = '0;
        if (MemRead && !err_c) Read_data = ram_hit_c ? lane_c : mmio_word_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick_q <= '0;
            led       <= '0;
            BCD       <= '0;
            mem_err   <= 1'b0;
        end else begin
            systick_q <= systick_q + 32'd1;
            mem_err   <= err_c;
            if (mmio_we_c && Address[5:2] == 4'h3) led <= Write_data[LED_W-1:0];
            if (mmio_we_c && Address[5:2] == 4'h4) BCD <= Write_data[11:0];
        end
    end

`ifdef DATA_MEM_TIMER_EN
    logic ovf_c;
    assign ovf_c = tcon_q[0] & (tl_q == 32'hFFFF_FFFF);

    // Software TL write beats hardware; hardware set of TCON[2] beats software clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            if (mmio_we_c && Address[5:2] == 4'h0) th_q <= Write_data;
            if (mmio_we_c && Address[5:2] == 4'h1) tl_q <= Write_data;
            else if (tcon_q[0])                   tl_q <= ovf_c ? th_q : tl_q + 32'd1;
            if (mmio_we_c && Address[5:2] == 4'h2) begin
                tcon_q[1:0] <= Write_data[1:0];
                tcon_q[2]   <= Write_data[2] | (ovf_c & tcon_q[1]);
            end else if (ovf_c && tcon_q[1]) begin
                tcon_q[2] <= 1'b1;
            end
        end
    end

    assign irq = tcon_q[1] & tcon_q[2];
`else
    assign th_q   = '0;
    assign tl_q   = '0;
    assign tcon_q = '0;
    assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed self-checking bench for data_mem_mmio (RAM lanes, errors, MMIO, reset, optional timer).
module tb_data_mem_mmio;

    localparam logic [31:0] MB = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, Write_data, Read_data;
    logic        MemRead, MemWrite, MemSigned;
    logic [1:0]  MemSize;
    logic [15:0] led;
    logic [11:0] BCD;
    logic        irq, mem_err;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_mmio dut (
        .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
        .Read_data(Read_data), .led(led), .BCD(BCD), .irq(irq), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        Address = a; Write_data = d; MemSize = sz; MemWrite = 1'b1; MemRead = 1'b0;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sgn,
                        output logic [31:0] d);
        Address = a; MemSize = sz; MemSigned = sgn; MemRead = 1'b1;
        #1;
        d = Read_data;
        MemRead = 1'b0;
        #1;
    endtask

    logic [31:0] r, s1;

    initial begin
        reset = 1'b0; Address = '0; Write_data = '0;
        MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b10; MemSigned = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_bcd", 32'(BCD), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_err", 32'(mem_err), 32'h0);
        load(MB + 32'h14, 2'b10, 1'b0, r);
        check("rst_systick_held", r, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        load(MB + 32'h14, 2'b10, 1'b0, r);
        check("systick_before_edge", r, 32'h0);
        @(posedge clk);
        #1;
        load(MB + 32'h14, 2'b10, 1'b0, r);
        check("systick_first_edge", r, 32'h1);
        load(MB + 32'h14, 2'b10, 1'b0, s1);
        repeat (5) @(posedge clk);
        #1;
        load(MB + 32'h14, 2'b10, 1'b0, r);
        check("systick_delta5", r - s1, 32'd5);

        // Lane extraction and byte stores
        store(32'h8, 32'h1234_5678, 2'b10);
        load(32'hB, 2'b00, 1'b0, r);  check("ld_byte_b_u", r, 32'h0000_0012);
        load(32'h8, 2'b10, 1'b0, r);  check("ld_word_8", r, 32'h1234_5678);
        store(32'h9, 32'h0000_0080, 2'b00);
        load(32'h8, 2'b01, 1'b1, r);  check("ld_half_8_s", r, 32'hFFFF_8078);
        load(32'h8, 2'b01, 1'b0, r);  check("ld_half_8_u", r, 32'h0000_8078);
        load(32'h9, 2'b00, 1'b1, r);  check("ld_byte_9_s", r, 32'hFFFF_FF80);
        load(32'hA, 2'b01, 1'b0, r);  check("ld_half_a_u", r, 32'h0000_1234);
        store(32'h6, 32'hABCD_BEEF, 2'b01);
        load(32'h4, 2'b10, 1'b0, r);  check("st_half_upper", r, 32'hBEEF_0000);
        check("no_err_good", 32'(mem_err), 32'h0);

        // Misaligned store, out-of-range load, reserved size
        store(32'h0, 32'hDEAD_BEEF, 2'b10);
        store(32'h3, 32'h0000_FFFF, 2'b01);
        check("err_mis_pulse", 32'(mem_err), 32'h1);
        load(32'h0, 2'b10, 1'b0, r);  check("err_mis_unchanged", r, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("err_mis_one_cycle", 32'(mem_err), 32'h0);
        @(negedge clk);
        Address = 32'h0000_1000; MemSize = 2'b10; MemRead = 1'b1;
        #1;
        check("err_oor_data", Read_data, 32'h0);
        @(posedge clk); #1;
        check("err_oor_pulse", 32'(mem_err), 32'h1);
        MemRead = 1'b0;
        @(posedge clk); #1;
        check("err_oor_clear", 32'(mem_err), 32'h0);
        @(negedge clk);
        Address = 32'h0; MemSize = 2'b11; MemRead = 1'b1;
        #1;
        check("err_size11_data", Read_data, 32'h0);
        @(posedge clk); #1;
        MemRead = 1'b0;
        check("err_size11_pulse", 32'(mem_err), 32'h1);
        load(MB + 32'h20, 2'b10, 1'b0, r);
        check("mmio_unmapped_rd", r, 32'h0);
        @(posedge clk); #1;
        check("mmio_unmapped_noerr", 32'(mem_err), 32'h0);

`ifdef DATA_MEM_TIMER_EN
        store(MB + 32'h0, 32'hFFFF_FFFC, 2'b10);
        store(MB + 32'h4, 32'hFFFF_FFFE, 2'b10);
        store(MB + 32'h8, 32'h0000_0003, 2'b10);
        load(MB + 32'h4, 2'b10, 1'b0, r);  check("tmr_tl_start", r, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        load(MB + 32'h4, 2'b10, 1'b0, r);  check("tmr_tl_ff", r, 32'hFFFF_FFFF);
        check("tmr_irq_low", 32'(irq), 32'h0);
        @(posedge clk); #1;
        load(MB + 32'h4, 2'b10, 1'b0, r);  check("tmr_tl_reload", r, 32'hFFFF_FFFC);
        check("tmr_irq_rise", 32'(irq), 32'h1);
        store(MB + 32'h8, 32'h0000_0003, 2'b10);
        check("tmr_irq_cleared", 32'(irq), 32'h0);
        store(MB + 32'h8, 32'h0000_0000, 2'b10);
        store(MB + 32'h4, 32'hFFFF_FFFF, 2'b10);
        store(MB + 32'h8, 32'h0000_0003, 2'b10);
        load(MB + 32'h4, 2'b10, 1'b0, r);  check("tmr_tl_armed", r, 32'hFFFF_FFFF);
        store(MB + 32'h4, 32'h0000_1234, 2'b10);
        load(MB + 32'h4, 2'b10, 1'b0, r);  check("tmr_sw_tl_wins", r, 32'h0000_1234);
        load(MB + 32'h8, 2'b10, 1'b0, r);  check("tmr_tcon_set", r, 32'h0000_0007);
        check("tmr_irq_sw_ovf", 32'(irq), 32'h1);
        store(MB + 32'h8, 32'h0000_0000, 2'b10);
`else
        store(MB + 32'h8, 32'h0000_0003, 2'b10);
        check("notmr_err", 32'(mem_err), 32'h0);
        load(MB + 32'h8, 2'b10, 1'b0, r);  check("notmr_tcon_rd", r, 32'h0);
        store(MB + 32'h4, 32'hFFFF_FFFF, 2'b10);
        load(MB + 32'h4, 2'b10, 1'b0, r);  check("notmr_tl_rd", r, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("notmr_irq", 32'(irq), 32'h0);
`endif

        // LED/BCD registers, then asynchronous reset mid-cycle
        store(MB + 32'hC, 32'hFFFF_A5A5, 2'b10);
        store(MB + 32'h10, 32'h0000_03F7, 2'b10);
        check("led_val", 32'(led), 32'h0000_A5A5);
        check("bcd_val", 32'(BCD), 32'h0000_03F7);
        load(MB + 32'hC, 2'b10, 1'b0, r);  check("led_rd", r, 32'h0000_A5A5);
        store(MB + 32'hC, 32'h0000_0011, 2'b00);
        check("led_narrow_whole", 32'(led), 32'h0000_0011);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_led", 32'(led), 32'h0);
        check("arst_bcd", 32'(BCD), 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        load(MB + 32'h14, 2'b10, 1'b0, r);  check("arst_systick", r, 32'h0);
        load(32'h8, 2'b10, 1'b0, r);        check("arst_ram", r, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        Address = 32'h10; Write_data = 32'h5555_5555; MemSize = 2'b10; MemWrite = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        MemWrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        load(32'h10, 2'b10, 1'b0, r);       check("arst_store_abort", r, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
